ir_fetch_cache: RTL and testbench
=================================

IR_FETCH_CACHE -- requirements
Module: ir_fetch_cache

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, meaning instruction word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 The block SHALL have parameter LINES, default 16 (power of 2), meaning direct-mapped line count.
REQ-004 The block SHALL have parameter WPL, default 4 (power of 2), meaning words per line.
REQ-005 clk input 1: clock. Reset rst, asynchronous, active-high; clock clk.
REQ-006 rst input 1: asynchronous active-high reset.
REQ-007 req_valid input 1: fetch request; req_addr input ADDR_W: byte address, word-aligned; req_ready output 1: request accepted when req_valid&&req_ready.
REQ-008 resp_valid output 1: one-cycle pulse qualifying resp_data output WORD_W: fetched instruction.
REQ-009 flush input 1: invalidate all lines.
REQ-010 mem_req_valid output 1, mem_req_addr output ADDR_W: line-aligned refill request, held until mem_req_ready input 1.
REQ-011 mem_resp_valid input 1, mem_resp_data input WORD_W: one refill beat per asserted cycle, words in ascending address order.

Function
REQ-012 Address split SHALL be: byte offset log2(WORD_W/8) bits (ignored), word offset log2(WPL), index log2(LINES), tag = remaining upper bits.
REQ-013 FSM states SHALL be IDLE, COMPARE, MISS_REQ, REFILL, RESP.
REQ-014 req_ready SHALL be 1 only in IDLE with flush=0.
REQ-015 IDLE: on accepted request, the block SHALL register req_addr and go to COMPARE.
REQ-016 COMPARE, hit (valid[index] && tag match): resp_valid=1 with the stored word, next state IDLE; hit latency is exactly 1 cycle after acceptance.
REQ-017 COMPARE, miss: next state MISS_REQ.
REQ-018 MISS_REQ: mem_req_valid=1, mem_req_addr = registered address with word and byte offset zeroed; on mem_req_ready, go to REFILL.
REQ-019 REFILL: a beat counter (0..WPL-1) SHALL write each mem_resp_data into the line; mem_resp_valid=0 cycles stall without penalty.
REQ-020 On the final beat, the block SHALL write the tag, set valid[index], and go to RESP.
REQ-021 RESP: resp_valid=1 with the requested word taken from the line, then IDLE.
REQ-022 resp_valid SHALL never assert in IDLE, MISS_REQ or REFILL.
REQ-023 flush in IDLE SHALL clear all valid bits in one cycle, with no request accepted that cycle.
REQ-024 flush outside IDLE SHALL be ignored; the requester holds it until seen.
REQ-025 The refill SHALL overwrite the line regardless of prior valid or tag state (no dirty state; read-only).

Reset
REQ-026 On rst, the block SHALL enter IDLE, clear all valid bits, zero the beat counter, and drive resp_valid=0, mem_req_valid=0, resp_data=0, mem_req_addr=0.
REQ-027 rst mid-refill SHALL abandon the refill with the line left invalid; beats arriving after reset release are ignored in IDLE.
REQ-028 The data and tag arrays SHALL not require reset.

Structure
REQ-029 FSM state encodings and default parameter values SHALL live in the shared defines file alongside WORD_WIDTH.
REQ-030 The data/tag/valid storage SHALL be one sub-module, ir_cache_line_store, with one write port and one read port; the FSM and counter stay in ir_fetch_cache.

Verification
REQ-031 Cold miss: reset, request 0x0000_0010, memory returns 4 beats 0xA0..0xA3 after 3-cycle mem_req_ready delay -> mem_req_addr=0x10, then resp_data=0xA0 in RESP.
REQ-032 Hit: next request 0x0000_001C -> resp_valid exactly 1 cycle after acceptance, resp_data=0xA3, no mem_req_valid.
REQ-033 Conflict: request 0x0000_0110 (same index, different tag) -> miss, refill to 0x110; then 0x10 misses again.
REQ-034 Stalled refill: mem_resp_valid toggles 1,0,0,1,1,0,1 -> exactly 4 writes; RESP follows the 4th beat.
REQ-035 Flush: after hits on 0x10, assert flush in IDLE for 1 cycle -> req_ready=0 that cycle; next 0x10 misses.
REQ-036 Reset mid-refill: assert rst after beat 2 -> resp_valid=0, mem_req_valid=0; next 0x10 misses and refills fully.

Source files
------------

// File: rtl/ir_fetch_cache_pkg.sv
// Shared defines for the instruction fetch cache: default geometry and FSM state encodings.
package ir_fetch_cache_pkg;

  localparam int WORD_WIDTH    = 32;
  localparam int ADDR_WIDTH    = 32;
  localparam int LINES_DEFAULT = 16;
  localparam int WPL_DEFAULT   = 4;

  typedef logic [2:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE     = 3'd0;
  localparam fsm_state_t ST_COMPARE  = 3'd1;
  localparam fsm_state_t ST_MISS_REQ = 3'd2;
  localparam fsm_state_t ST_REFILL   = 3'd3;
  localparam fsm_state_t ST_RESP     = 3'd4;

endpackage

// File: rtl/ir_fetch_cache_if.sv
// Fetch request/response and line-refill memory port of the instruction fetch cache.
interface ir_fetch_cache_if
  import ir_fetch_cache_pkg::*;
#(
  parameter int WORD_W = WORD_WIDTH,
  parameter int ADDR_W = ADDR_WIDTH
) ();

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_data;
  logic              flush;

  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [WORD_W-1:0] mem_resp_data;

  // Cache side.
  modport slave (
    input  req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
  );

  // Requester and memory side.
  modport master (
    output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
  );

endinterface

// File: rtl/ir_cache_line_store.sv
// Direct-mapped line storage: word data, per-line tag and valid bits.
// One write port (refill beat, tag/valid set on the final beat) and one combinational read port.
module ir_cache_line_store
  import ir_fetch_cache_pkg::*;
#(
  parameter int WORD_W = WORD_WIDTH,
  parameter int LINES  = LINES_DEFAULT,
  parameter int WPL    = WPL_DEFAULT,
  parameter int TAG_W  = 24,
  localparam int IDX_W  = $clog2(LINES),
  localparam int WOFF_W = $clog2(WPL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_all,
  input  logic              wr_en,
  input  logic              wr_last,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WOFF_W-1:0] wr_woff,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WOFF_W-1:0] rd_woff,
  output logic [WORD_W-1:0] rd_data,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid
);

  logic [WORD_W-1:0] data_r [LINES*WPL];
  logic [TAG_W-1:0]  tag_r  [LINES];
  logic [LINES-1:0]  valid_r;

  // Refill beat write into the word array; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_r[{wr_idx, wr_woff}] <= wr_data;
    end
  end

  // Tag is written once per refill, on the beat that completes the line.
  always_ff @(posedge clk) begin
    if (wr_en && wr_last) begin
      tag_r[wr_idx] <= wr_tag;
    end
  end

  // Valid bits: cleared by reset or flush, set only when a whole line has landed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= {LINES{1'b0}};
    end else if (clear_all) begin
      valid_r <= {LINES{1'b0}};
    end else if (wr_en && wr_last) begin
      valid_r[wr_idx] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign rd_data  = data_r[{rd_idx, rd_woff}];
  assign rd_tag   = tag_r[rd_idx];
  assign rd_valid = valid_r[rd_idx];

endmodule

// File: rtl/ir_fetch_cache.sv
// Direct-mapped read-only instruction fetch cache. The tag lookup runs against the incoming
// address in IDLE so a hit can be presented from registered outputs in the COMPARE cycle.
module ir_fetch_cache
  import ir_fetch_cache_pkg::*;
#(
  parameter int WORD_W = WORD_WIDTH,
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int LINES  = LINES_DEFAULT,
  parameter int WPL    = WPL_DEFAULT
) (
  input logic clk,
  input logic rst,
  ir_fetch_cache_if.slave bus
);

  localparam int BOFF_W = $clog2(WORD_W / 8);
  localparam int WOFF_W = $clog2(WPL);
  localparam int IDX_W  = $clog2(LINES);
  localparam int WA_W   = ADDR_W - BOFF_W;
  localparam int TAG_W  = WA_W - WOFF_W - IDX_W;
  localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(WPL - 1);

  fsm_state_t        state_r;
  fsm_state_t        state_nxt_s;
  logic [WA_W-1:0]   addr_r;
  logic [WOFF_W-1:0] cnt_r;
  logic              resp_valid_r;
  logic [WORD_W-1:0] resp_data_r;
  logic              mem_req_valid_r;
  logic [ADDR_W-1:0] mem_req_addr_r;

  logic [WA_W-1:0]   req_wa_s;
  logic [BOFF_W-1:0] unused_byte_off_s;
  logic              accept_s;
  logic              hit_s;
  logic              beat_s;
  logic              last_beat_s;
  logic              clear_all_s;
  logic [WORD_W-1:0] rd_data_s;
  logic [TAG_W-1:0]  rd_tag_s;
  logic              rd_valid_s;

  // Byte offset within a word carries no information for a word-aligned fetch.
  assign unused_byte_off_s = bus.req_addr[BOFF_W-1:0];
  assign req_wa_s          = bus.req_addr[ADDR_W-1:BOFF_W];

  assign bus.req_ready = (state_r == ST_IDLE) && !bus.flush;
  assign accept_s      = (state_r == ST_IDLE) && !bus.flush && bus.req_valid;
  assign clear_all_s   = (state_r == ST_IDLE) && bus.flush;
  assign hit_s         = rd_valid_s && (rd_tag_s == req_wa_s[WA_W-1 -: TAG_W]);
  assign beat_s        = (state_r == ST_REFILL) && bus.mem_resp_valid;
  assign last_beat_s   = beat_s && (cnt_r == LAST_BEAT);

  ir_cache_line_store #(
    .WORD_W (WORD_W),
    .LINES  (LINES),
    .WPL    (WPL),
    .TAG_W  (TAG_W)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .clear_all (clear_all_s),
    .wr_en     (beat_s),
    .wr_last   (last_beat_s),
    .wr_idx    (addr_r[WOFF_W +: IDX_W]),
    .wr_woff   (cnt_r),
    .wr_data   (bus.mem_resp_data),
    .wr_tag    (addr_r[WA_W-1 -: TAG_W]),
    .rd_idx    (req_wa_s[WOFF_W +: IDX_W]),
    .rd_woff   (req_wa_s[WOFF_W-1:0]),
    .rd_data   (rd_data_s),
    .rd_tag    (rd_tag_s),
    .rd_valid  (rd_valid_s)
  );

  // Next-state selection; in COMPARE the registered response flag doubles as the hit flag.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_COMPARE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        if (resp_valid_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        if (bus.mem_req_ready) begin
          state_nxt_s = ST_REFILL;
        end else begin
          state_nxt_s = ST_MISS_REQ;
        end
      end
      ST_REFILL: begin
        if (last_beat_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_REFILL;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request address, beat counter and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r          <= {WA_W{1'b0}};
      cnt_r           <= {WOFF_W{1'b0}};
      resp_valid_r    <= 1'b0;
      resp_data_r     <= {WORD_W{1'b0}};
      mem_req_valid_r <= 1'b0;
      mem_req_addr_r  <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            addr_r       <= req_wa_s;
            resp_valid_r <= hit_s;
            resp_data_r  <= rd_data_s;
          end
        end
        ST_COMPARE: begin
          resp_valid_r <= 1'b0;
          if (!resp_valid_r) begin
            mem_req_valid_r <= 1'b1;
            mem_req_addr_r  <= {addr_r[WA_W-1:WOFF_W], {(BOFF_W + WOFF_W){1'b0}}};
          end
        end
        ST_MISS_REQ: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
            cnt_r           <= {WOFF_W{1'b0}};
          end
        end
        ST_REFILL: begin
          // The requested word is captured as its beat passes, so RESP needs no extra read.
          if (beat_s) begin
            cnt_r        <= cnt_r + WOFF_W'(1);
            resp_valid_r <= last_beat_s;
            if (cnt_r == addr_r[WOFF_W-1:0]) begin
              resp_data_r <= bus.mem_resp_data;
            end
          end
        end
        ST_RESP: begin
          resp_valid_r <= 1'b0;
        end
        default: begin
          resp_valid_r    <= 1'b0;
          mem_req_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.resp_valid    = resp_valid_r;
  assign bus.resp_data     = resp_data_r;
  assign bus.mem_req_valid = mem_req_valid_r;
  assign bus.mem_req_addr  = mem_req_addr_r;

endmodule

// File: tb/tb_ir_fetch_cache.sv
// Scoreboard bench for ir_fetch_cache: directed scenarios plus randomized fetches against
// an array-based cache/memory reference model.
module tb_ir_fetch_cache;
  import ir_fetch_cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ir_fetch_cache_if #(.WORD_W(32), .ADDR_W(32)) bus ();

  ir_fetch_cache #(.WORD_W(32), .ADDR_W(32), .LINES(16), .WPL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    bit          hit;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mreq_q[$];
  logic [31:0] mem_m [1024];
  bit          valid_m [16];
  logic [23:0] tag_m [16];
  logic [31:0] data_m [16][4];

  int n_cmp = 0;
  int n_fail = 0;
  int pcyc = 0;
  int last_beat_cyc = 0;
  int beats_sent = 0;
  int fix_delay = 3;
  bit resp_busy = 1'b0;
  bit stall_mode = 1'b0;
  logic [6:0] stall_pat = 7'b1011001;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a fetch hits iff its line holds the same tag; a miss copies the whole line from memory.
  function automatic void model_req(input logic [31:0] a, input int acc);
    int idx = int'(a[7:4]);
    int w   = int'(a[3:2]);
    bit hit = valid_m[idx] && (tag_m[idx] == a[31:8]);
    if (!hit) begin
      for (int k = 0; k < 4; k++) data_m[idx][k] = mem_m[{a[11:4], 2'(k)}];
      tag_m[idx]   = a[31:8];
      valid_m[idx] = 1'b1;
      mreq_q.push_back({a[31:4], 4'h0});
    end
    exp_q.push_back('{data_m[idx][w], hit, acc});
  endfunction

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() != 0 || resp_busy || bus.mem_req_valid) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: pending=%0d busy=%0d, required idle within 400 cycles", exp_q.size(), resp_busy);
      exp_q.delete();
    end
  endtask

  task automatic do_req(input logic [31:0] a, input bit wait_done);
    int guard = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    while (!bus.req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL req_accept: addr=%h never accepted, required acceptance", a);
    end else begin
      model_req(a, pcyc);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (wait_done) wait_idle();
  endtask

  task automatic do_flush();
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0010;
    #1;
    check("flush_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 16; i++) valid_m[i] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_mem_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
    check({tag, "_resp_data"}, bus.resp_data, 32'd0);
    check({tag, "_mem_req_addr"}, bus.mem_req_addr, 32'd0);
  endtask

  // Monitor: every response pulse must match the oldest expectation, data and latency.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_resp: resp_valid=1 data=%h, required no response", bus.resp_data);
        end else begin
          e = exp_q.pop_front();
          check("resp_data", bus.resp_data, e.data);
          if (e.hit) check("hit_latency", 32'(pcyc), 32'(e.acc + 1));
          else       check("miss_latency", 32'(pcyc), 32'(last_beat_cyc + 1));
        end
      end
    end
  end

  // Memory responder: checks each refill request, delays ready, then streams beats with stalls.
  initial begin : responder
    logic [31:0] line;
    int d;
    int k;
    int slot;
    bit v;
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_req_valid) begin
        resp_busy  = 1'b1;
        beats_sent = 0;
        if (mreq_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_mem_req: addr=%h, required no refill", bus.mem_req_addr);
          line = bus.mem_req_addr;
        end else begin
          line = mreq_q.pop_front();
          check("mem_req_addr", bus.mem_req_addr, line);
        end
        d = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 4));
        repeat (d) begin
          @(negedge clk);
          check("mem_req_hold", {31'd0, bus.mem_req_valid}, 32'd1);
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        check("mem_req_drop", {31'd0, bus.mem_req_valid}, 32'd0);
        k = 0;
        slot = 0;
        while (k < 4 && slot < 64) begin
          if (stall_mode) v = (slot < 7) ? stall_pat[slot] : 1'b1;
          else            v = ($urandom_range(0, 3) != 0);
          bus.mem_resp_valid = v;
          bus.mem_resp_data  = v ? mem_m[{line[11:4], 2'(k)}] : $urandom;
          if (v) begin
            k++;
            beats_sent = k;
            if (k == 4) last_beat_cyc = pcyc;
          end
          slot++;
          @(negedge clk);
        end
        bus.mem_resp_valid = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int guard;
    logic [31:0] a;
    bus.req_valid      = 1'b0;
    bus.req_addr       = 32'd0;
    bus.flush          = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'd0;
    for (int i = 0; i < 1024; i++) mem_m[i] = $urandom;
    for (int i = 0; i < 4; i++) mem_m[4 + i] = 32'hA0 + 32'(i);
    for (int i = 0; i < 16; i++) valid_m[i] = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    rst = 1'b0;

    // Cold miss, hit, conflict eviction and re-miss.
    do_req(32'h0000_0010, 1'b1);
    do_req(32'h0000_001C, 1'b1);
    fix_delay = -1;
    do_req(32'h0000_0110, 1'b1);
    do_req(32'h0000_0010, 1'b1);

    // Refill with stalled beats.
    stall_mode = 1'b1;
    do_req(32'h0000_0024, 1'b1);
    stall_mode = 1'b0;

    // Hits, then flush forces a miss.
    do_req(32'h0000_0010, 1'b1);
    do_req(32'h0000_0014, 1'b1);
    do_flush();
    do_req(32'h0000_0010, 1'b1);

    // Reset in the middle of a refill.
    do_req(32'h0000_0110, 1'b0);
    beats_sent = 0;
    guard = 0;
    while (beats_sent < 2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("rst_mid_beats", 32'(beats_sent >= 2), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 16; i++) valid_m[i] = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle();
    do_req(32'h0000_0010, 1'b1);

    // Randomized fetches over a few tags per index, with occasional flushes and memory edits.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) do_flush();
      if ($urandom_range(0, 3) == 0) mem_m[$urandom_range(0, 255)] = $urandom;
      a = {22'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00};
      do_req(a, 1'b1);
    end

    wait_idle();
    repeat (4) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("mreq_q_drained", 32'(mreq_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
